// File: rtl/display_source_sel_if.sv
// Bundle between the display source selector and its environment: key/scan
// controls and source values in, selected index and clamped value out.
interface display_source_sel_if #(
  parameter int N_SRC = 4,
  parameter int SEL_W = 2
);
  logic                 key_n;
  logic                 auto_en;
  logic                 freeze;
  logic [8*N_SRC-1:0]   src_bus;
  logic [SEL_W-1:0]     sel_out;
  logic [7:0]           num_out;
  logic                 ovf;
  logic                 press;

  modport master (
    output key_n, auto_en, freeze, src_bus,
    input  sel_out, num_out, ovf, press
  );

  modport slave (
    input  key_n, auto_en, freeze, src_bus,
    output sel_out, num_out, ovf, press
  );
endinterface

// File: rtl/display_source_sel.sv
// Picks one of N_SRC debug bytes for the two-digit readout, clamps it to 0..99
// and steps the selection on a debounced key press or a periodic scan tick.
module display_source_sel #(
  parameter int N_SRC           = 4,
  parameter int SEL_W           = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SCAN_PERIOD     = 50000000
) (
  input logic                clk,
  input logic                rst_n,
  display_source_sel_if.slave bus
);

  typedef enum logic {RELEASED, PRESSED} db_state_e;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SC_W = $clog2(SCAN_PERIOD);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SCAN_PERIOD - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_SRC - 1);

  logic             sync1_q;
  logic             key_s_q;
  db_state_e        db_state_q;
  logic [DB_W-1:0]  db_cnt_q;
  logic             press_q;
  logic [SC_W-1:0]  scan_q, scan_d;
  logic             scan_tick;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [7:0]       src_val;
  logic [7:0]       num_q, num_d;
  logic             ovf_q, ovf_d;

  // Two-flop synchronizer; idles high so a held key is not seen out of reset.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      key_s_q <= 1'b1;
    end else begin
      sync1_q <= bus.key_n;
      key_s_q <= sync1_q;
    end
  end

  // Debouncer: a level is accepted after DEBOUNCE_CYCLES consecutive samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_state_q <= RELEASED;
      db_cnt_q   <= '0;
      press_q    <= 1'b0;
    end else begin
      press_q <= 1'b0;
      unique case (db_state_q)
        RELEASED: begin
          if (key_s_q) begin
            db_cnt_q <= '0;
          end else if (db_cnt_q == DB_LAST) begin
            db_state_q <= PRESSED;
            db_cnt_q   <= '0;
            press_q    <= 1'b1;
          end else begin
            db_cnt_q <= db_cnt_q + DB_W'(1);
          end
        end
        PRESSED: begin
          if (!key_s_q) begin
            db_cnt_q <= '0;
          end else if (db_cnt_q == DB_LAST) begin
            db_state_q <= RELEASED;
            db_cnt_q   <= '0;
          end else begin
            db_cnt_q <= db_cnt_q + DB_W'(1);
          end
        end
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    scan_tick = bus.auto_en && (scan_q == SC_LAST);
    scan_d    = scan_q + SC_W'(1);
    if (!bus.auto_en || press_q || scan_tick) scan_d = '0;

    // A forced out-of-range index also wraps to 0 on the next step.
    sel_d = sel_q;
    if (press_q || scan_tick) sel_d = (sel_q >= SEL_LAST) ? '0 : sel_q + SEL_W'(1);

    src_val = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (sel_q == SEL_W'(k)) src_val = bus.src_bus[8*k +: 8];
    end

    num_d = num_q;
    ovf_d = ovf_q;
    if (!bus.freeze) begin
      ovf_d = (src_val > 8'd99);
      num_d = ovf_d ? 8'd99 : src_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_q <= '0;
      sel_q  <= '0;
      num_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      scan_q <= scan_d;
      sel_q  <= sel_d;
      num_q  <= num_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.sel_out = sel_q;
  assign bus.num_out = num_q;
  assign bus.ovf     = ovf_q;
  assign bus.press   = press_q;

endmodule

// File: tb/tb_display_source_sel.sv
// Directed bench for display_source_sel: reset, clamping, debounce, wrap,
// auto scan with press coincidence, freeze and reset mid-operation.
module tb_display_source_sel;

  localparam int N_SRC = 4;
  localparam int SEL_W = 2;
  localparam int DB    = 4;
  localparam int SP    = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int exp_num [4] = '{5, 42, 99, 99};
  int exp_ovf [4] = '{0, 0, 0, 1};

  display_source_sel_if #(.N_SRC(N_SRC), .SEL_W(SEL_W)) dut_if ();

  display_source_sel #(
    .N_SRC(N_SRC), .SEL_W(SEL_W), .DEBOUNCE_CYCLES(DB), .SCAN_PERIOD(SP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (dut_if.slave)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    dut_if.key_n   = 1'b1;
    dut_if.auto_en = 1'b0;
    dut_if.freeze  = 1'b0;
    dut_if.src_bus = {8'd100, 8'd99, 8'd42, 8'd5};
    step(1);
    rst_n = 1'b1;
  endtask

  // Key low long enough for the selection to have advanced at the last edge.
  task automatic press_key();
    dut_if.key_n = 1'b0;
    step(DB + 3);
  endtask

  task automatic release_key();
    dut_if.key_n = 1'b1;
    step(DB + 2);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (dut_if.sel_out !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", dut_if.sel_out); end
    checks++; if (dut_if.num_out !== 8'd0) begin errors++; $display("FAIL reset_num: got %0d expected 0", dut_if.num_out); end
    checks++; if (dut_if.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", dut_if.ovf); end
    checks++; if (dut_if.press !== 1'b0) begin errors++; $display("FAIL reset_press: got %0b expected 0", dut_if.press); end
    step(1);
    checks++; if (dut_if.num_out !== 8'd5) begin errors++; $display("FAIL reset_first_num: got %0d expected 5", dut_if.num_out); end
  endtask

  task automatic test_clamp();
    for (int k = 1; k < 4; k++) begin
      press_key();
      checks++; if (dut_if.sel_out !== SEL_W'(k)) begin errors++; $display("FAIL clamp_sel%0d: got %0d expected %0d", k, dut_if.sel_out, k); end
      release_key();
      checks++; if (dut_if.num_out !== 8'(exp_num[k])) begin errors++; $display("FAIL clamp_num%0d: got %0d expected %0d", k, dut_if.num_out, exp_num[k]); end
      checks++; if (dut_if.ovf !== 1'(exp_ovf[k])) begin errors++; $display("FAIL clamp_ovf%0d: got %0b expected %0d", k, dut_if.ovf, exp_ovf[k]); end
    end
    dut_if.src_bus[31:24] = 8'd255;
    step(1);
    checks++; if (dut_if.num_out !== 8'd99) begin errors++; $display("FAIL clamp_255_num: got %0d expected 99", dut_if.num_out); end
    checks++; if (dut_if.ovf !== 1'b1) begin errors++; $display("FAIL clamp_255_ovf: got %0b expected 1", dut_if.ovf); end
    dut_if.src_bus[31:24] = 8'd100;
  endtask

  task automatic test_wrap();
    int prev;
    int nxt;
    apply_reset();
    step(1);
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      nxt = (prev + 1) % 4;
      press_key();
      checks++; if (dut_if.sel_out !== SEL_W'(nxt)) begin errors++; $display("FAIL wrap_sel%0d: got %0d expected %0d", k, dut_if.sel_out, nxt); end
      checks++; if (dut_if.num_out !== 8'(exp_num[prev])) begin errors++; $display("FAIL wrap_lag%0d: got %0d expected %0d", k, dut_if.num_out, exp_num[prev]); end
      step(1);
      checks++; if (dut_if.num_out !== 8'(exp_num[nxt])) begin errors++; $display("FAIL wrap_num%0d: got %0d expected %0d", k, dut_if.num_out, exp_num[nxt]); end
      release_key();
      prev = nxt;
    end
  endtask

  task automatic test_debounce();
    int saw;
    int first;
    int cnt;
    apply_reset();
    saw = 0;
    for (int i = 0; i < 10; i++) begin
      dut_if.key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      for (int c = 0; c < 2; c++) begin
        step(1);
        if (dut_if.press === 1'b1) saw++;
      end
    end
    checks++; if (saw !== 0) begin errors++; $display("FAIL bounce_press: got %0d pulses expected 0", saw); end
    dut_if.key_n = 1'b0;
    first = 0;
    cnt   = 0;
    for (int j = 1; j <= 110; j++) begin
      step(1);
      if (dut_if.press === 1'b1) begin
        cnt++;
        if (first == 0) first = j;
      end
    end
    checks++; if (first !== DB + 2) begin errors++; $display("FAIL db_latency: got edge %0d expected %0d", first, DB + 2); end
    checks++; if (cnt !== 1) begin errors++; $display("FAIL db_single: got %0d pulses expected 1", cnt); end
    checks++; if (dut_if.sel_out !== 2'd1) begin errors++; $display("FAIL db_sel: got %0d expected 1", dut_if.sel_out); end
    release_key();
  endtask

  task automatic test_auto_scan();
    apply_reset();
    dut_if.auto_en = 1'b1;
    for (int j = 1; j <= 24; j++) begin
      step(1);
      if (j == SP - 1) begin checks++; if (dut_if.sel_out !== 2'd0) begin errors++; $display("FAIL scan_pre: got %0d expected 0", dut_if.sel_out); end end
      if (j == SP)     begin checks++; if (dut_if.sel_out !== 2'd1) begin errors++; $display("FAIL scan_1: got %0d expected 1", dut_if.sel_out); end end
      if (j == 2 * SP) begin checks++; if (dut_if.sel_out !== 2'd2) begin errors++; $display("FAIL scan_2: got %0d expected 2", dut_if.sel_out); end end
      if (j == 3 * SP) begin checks++; if (dut_if.sel_out !== 2'd3) begin errors++; $display("FAIL scan_3: got %0d expected 3", dut_if.sel_out); end end
    end
    dut_if.auto_en = 1'b0;
    step(20);
    checks++; if (dut_if.sel_out !== 2'd3) begin errors++; $display("FAIL scan_off: got %0d expected 3", dut_if.sel_out); end

    // Key sampled one edge after scanning starts, so press lands on the tick cycle.
    apply_reset();
    dut_if.auto_en = 1'b1;
    step(1);
    dut_if.key_n = 1'b0;
    for (int j = 2; j <= 16; j++) begin
      step(1);
      if (j == 7) begin
        checks++; if (dut_if.press !== 1'b1) begin errors++; $display("FAIL coin_press: got %0b expected 1", dut_if.press); end
        checks++; if (dut_if.sel_out !== 2'd0) begin errors++; $display("FAIL coin_pre: got %0d expected 0", dut_if.sel_out); end
      end
      if (j == 8)  begin checks++; if (dut_if.sel_out !== 2'd1) begin errors++; $display("FAIL coin_once: got %0d expected 1", dut_if.sel_out); end end
      if (j == 15) begin checks++; if (dut_if.sel_out !== 2'd1) begin errors++; $display("FAIL coin_hold: got %0d expected 1", dut_if.sel_out); end end
      if (j == 16) begin checks++; if (dut_if.sel_out !== 2'd2) begin errors++; $display("FAIL coin_next: got %0d expected 2", dut_if.sel_out); end end
    end
    dut_if.auto_en = 1'b0;
    release_key();
  endtask

  task automatic test_freeze();
    apply_reset();
    step(1);
    press_key();
    release_key();
    checks++; if (dut_if.num_out !== 8'd42) begin errors++; $display("FAIL frz_setup: got %0d expected 42", dut_if.num_out); end
    dut_if.freeze  = 1'b1;
    dut_if.src_bus = {8'd200, 8'd77, 8'd11, 8'd33};
    step(2);
    checks++; if (dut_if.num_out !== 8'd42) begin errors++; $display("FAIL frz_src: got %0d expected 42", dut_if.num_out); end
    press_key();
    checks++; if (dut_if.sel_out !== 2'd2) begin errors++; $display("FAIL frz_sel: got %0d expected 2", dut_if.sel_out); end
    release_key();
    checks++; if (dut_if.num_out !== 8'd42) begin errors++; $display("FAIL frz_hold: got %0d expected 42", dut_if.num_out); end
    checks++; if (dut_if.ovf !== 1'b0) begin errors++; $display("FAIL frz_ovf: got %0b expected 0", dut_if.ovf); end
    dut_if.freeze = 1'b0;
    step(1);
    checks++; if (dut_if.num_out !== 8'd77) begin errors++; $display("FAIL frz_release: got %0d expected 77", dut_if.num_out); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    dut_if.auto_en = 1'b1;
    step(1);
    dut_if.key_n = 1'b0;
    step(4);
    checks++; if (dut_if.num_out !== 8'd5) begin errors++; $display("FAIL mid_pre: got %0d expected 5", dut_if.num_out); end
    rst_n = 1'b0;
    step(1);
    checks++; if (dut_if.sel_out !== 2'd0) begin errors++; $display("FAIL mid_sel: got %0d expected 0", dut_if.sel_out); end
    checks++; if (dut_if.num_out !== 8'd0) begin errors++; $display("FAIL mid_num: got %0d expected 0", dut_if.num_out); end
    checks++; if (dut_if.ovf !== 1'b0) begin errors++; $display("FAIL mid_ovf: got %0b expected 0", dut_if.ovf); end
    checks++; if (dut_if.press !== 1'b0) begin errors++; $display("FAIL mid_press0: got %0b expected 0", dut_if.press); end
    rst_n = 1'b1;
    for (int j = 1; j <= 15; j++) begin
      step(1);
      if (j == 1)  begin checks++; if (dut_if.num_out !== 8'd5) begin errors++; $display("FAIL mid_num5: got %0d expected 5", dut_if.num_out); end end
      if (j == 5)  begin checks++; if (dut_if.press !== 1'b0) begin errors++; $display("FAIL mid_early: got %0b expected 0", dut_if.press); end end
      if (j == 6)  begin checks++; if (dut_if.press !== 1'b1) begin errors++; $display("FAIL mid_press: got %0b expected 1", dut_if.press); end end
      if (j == 7)  begin checks++; if (dut_if.sel_out !== 2'd1) begin errors++; $display("FAIL mid_step: got %0d expected 1", dut_if.sel_out); end end
      if (j == 8)  begin checks++; if (dut_if.sel_out !== 2'd1) begin errors++; $display("FAIL mid_restart: got %0d expected 1", dut_if.sel_out); end end
      if (j == 14) begin checks++; if (dut_if.sel_out !== 2'd1) begin errors++; $display("FAIL mid_period: got %0d expected 1", dut_if.sel_out); end end
      if (j == 15) begin checks++; if (dut_if.sel_out !== 2'd2) begin errors++; $display("FAIL mid_tick: got %0d expected 2", dut_if.sel_out); end end
    end
    dut_if.auto_en = 1'b0;
    release_key();
  endtask

  initial begin
    dut_if.key_n   = 1'b1;
    dut_if.auto_en = 1'b0;
    dut_if.freeze  = 1'b0;
    dut_if.src_bus = '0;
    step(1);
    test_reset();
    test_clamp();
    test_wrap();
    test_debounce();
    test_auto_scan();
    test_freeze();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_source_sel.md
# display_source_sel

Front-end stage for the two-digit seven-segment readout. Each cycle it picks one of `N_SRC` 8-bit debug values (PC low byte, selected register, ALU result, …), clamps it to the 0–99 range, and presents it registered on `num_out` to the binary-to-two-digit seven-segment mapper. The displayed source changes either on a debounced pushbutton press or automatically at a fixed scan period.

## Interface
- `N_SRC`, default 4: number of selectable sources, 2..16.
- `SEL_W`, default 2: width of `sel_out`; equals ceil(log2(`N_SRC`)).
- `DEBOUNCE_CYCLES`, default 16: number of consecutive stable synchronized samples required to accept a key level change; ≥2.
- `SCAN_PERIOD`, default 50000000: number of cycles between automatic advances; ≥2.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `key_n`  in  1  raw pushbutton, active-low, asynchronous and bouncing.
- `auto_en`  in  1  1 = automatic scan enabled.
- `freeze`  in  1  1 = hold `num_out` and `ovf`.
- `src_bus`  in  8*`N_SRC`  source k occupies bits [8k+7:8k].
- `sel_out`  out  `SEL_W`  index of the current source.
- `num_out`  out  8  clamped value for the display mapper, 0..99.
- `ovf`  out  1  1 = the selected source exceeded 99 and was clamped.
- `press`  out  1  one-cycle pulse on an accepted key press.

## Operation
- Reset (`rst_n` = 0 at a rising edge): `sel_out` = 0, `num_out` = 0, `ovf` = 0, `press` = 0, debounced key state = released, debounce and scan counters = 0, both synchronizer flops = 1.
- Synchronizer: two flops on `key_n`. Only the second flop's output, `key_s`, feeds the logic.
- Debouncer FSM, states RELEASED and PRESSED:
  - In RELEASED, the counter increments while `key_s` = 0 and clears when `key_s` = 1. When the counter reaches `DEBOUNCE_CYCLES`, the FSM moves to PRESSED, the counter clears, and `press` = 1 for exactly that cycle.
  - PRESSED behaves symmetrically on `key_s` = 1 and returns to RELEASED with no pulse.
  - A single glitch resets the count.
- Scan counter:
  - Held at 0 when `auto_en` = 0.
  - Otherwise it counts 0..`SCAN_PERIOD`-1. The cycle it wraps is the scan tick.
  - `press` also clears it, so a manual step restarts the full period.
- Selector:
  - On `press` OR scan tick, `sel_out` = `sel_out`+1, wrapping from `N_SRC`-1 to 0.
  - If `press` and a scan tick coincide, `sel_out` advances once and the counter clears.
  - `sel_out` ≥ `N_SRC` is unreachable. If it is forced, the next advance goes to 0.
- Output register, updated every cycle unless `freeze` = 1:
  - v = source[`sel_out`] as registered this cycle.
  - v ≤ 99: `num_out` = v, `ovf` = 0.
  - v ≥ 100: `num_out` = 99, `ovf` = 1.
  - The comparison is unsigned over 8 bits.
- `freeze`:
  - Holds `num_out` and `ovf` only.
  - `sel_out`, the debouncer and scanning keep running. On release, the output reflects the current selection one cycle later.

## Timing
- Output latency: a change on `src_bus` or `sel_out` appears on `num_out` after one rising edge.
- Key path. Let `key_n` be stably 0, first sampled at edge E0.
  - `key_s` = 0 from edge E0+1.
  - `press` is high after edge E0+`DEBOUNCE_CYCLES`+1.
  - `sel_out` advances at edge E0+`DEBOUNCE_CYCLES`+2.
  - `num_out` shows the new source at edge E0+`DEBOUNCE_CYCLES`+3.
- Holding the key generates one `press` only; there is no auto-repeat.
- A new press needs `DEBOUNCE_CYCLES` stable released samples first.
- Scan: with `auto_en` held at 1 from reset release, `sel_out` advances every `SCAN_PERIOD` cycles. The first advance happens `SCAN_PERIOD` edges after the first edge with `auto_en` = 1.
- Reset asserted mid-debounce or mid-scan: all state returns to reset values at that edge. A key still held after reset must re-debounce from RELEASED and produces a fresh `press`.

## Test plan
- Reset/clamp (`N_SRC`=4, sources = 5, 42, 99, 100): after reset, `num_out` = 0 and `sel_out` = 0. One cycle later `num_out` = 5. Stepping `sel_out` through the sources gives 42/`ovf`=0, 99/`ovf`=0, then 99/`ovf`=1. Source value 255 gives 99/`ovf`=1.
- Debounce (`DEBOUNCE_CYCLES`=4): `key_n` toggles every 2 cycles for 20 cycles, then holds 0.
  - No `press` during the toggling.
  - Exactly one `press`, 6 edges after the first stable-low sample; `sel_out` goes 0→1.
  - Holding for 100 more cycles gives no further `press`.
- Wrap: four presses starting at `sel_out` = 0 give `sel_out` 1, 2, 3, 0, with `num_out` following one cycle behind.
- Auto scan (`SCAN_PERIOD`=8): `auto_en` = 1 advances `sel_out` every 8 cycles. A press landing on a scan-tick cycle gives a single +1, and the next tick comes 8 cycles later. `auto_en` = 0 stops advances.
- Freeze: `num_out` = 42, then `freeze` = 1 while `src_bus` changes and a press occurs. `num_out` stays 42 while `sel_out` advances. One edge after `freeze` drops, `num_out` shows the new source.
- Reset mid-operation: assert `rst_n` = 0 with `key_n` low after 2 of 4 debounce samples and the scan counter at 5.
  - All outputs are 0 after that edge.
  - After release with the key still low, `press` fires 6 edges later (E0 = first edge after reset release), and the scan restarts its full 8-cycle period.
